// File: rtl/midi_pkg.sv
// Shared types and byte constants for the MIDI message parser.
// Message type encoding equals the low three bits of the channel status nibble.
// No logic here; types and constants only.
package midi_pkg;

  typedef enum logic [2:0] {
    NOTE_OFF = 3'd0,
    NOTE_ON  = 3'd1,
    POLY_AT  = 3'd2,
    CC       = 3'd3,
    PROG     = 3'd4,
    CHAN_AT  = 3'd5,
    PBEND    = 3'd6
  } msg_type_t;

  localparam logic [3:0] ST_NOTE_OFF = 4'h8;
  localparam logic [3:0] ST_NOTE_ON  = 4'h9;
  localparam logic [3:0] ST_POLY_AT  = 4'hA;
  localparam logic [3:0] ST_CC       = 4'hB;
  localparam logic [3:0] ST_PROG     = 4'hC;
  localparam logic [3:0] ST_CHAN_AT  = 4'hD;
  localparam logic [3:0] ST_PBEND    = 4'hE;

  localparam logic [7:0] SYS_EX = 8'hF0;
  localparam logic [7:0] EOX    = 8'hF7;
  localparam logic [7:0] RT_MIN = 8'hF8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_D1,
    S_WAIT_D2,
    S_SYSEX,
    S_SKIP1,
    S_SKIP2
  } parse_state_t;

  // 8..E map onto 0..6 by dropping the top bit of the status nibble.
  function automatic msg_type_t nibble_to_type(input logic [3:0] nib);
    return msg_type_t'(nib[2:0]);
  endfunction

endpackage

// File: rtl/midi_msg_parser.sv
// Byte-level MIDI parser: running status, SysEx/system-common skip, realtime split.
// Latency: message valid 1 cycle after final data byte; realtime pulse 1 cycle after its byte.
// Backpressure: every input byte stalls while the message register is full and not being taken.
module midi_msg_parser
  import midi_pkg::*;
#(
  parameter bit VEL0_IS_OFF = 1'b1,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             omni,
  input  logic [3:0]       channel,
  output msg_type_t        msg_type,
  output logic [3:0]       msg_chan,
  output logic [6:0]       msg_d1,
  output logic [6:0]       msg_d2,
  output logic             msg_valid,
  input  logic             msg_ready,
  output logic [7:0]       rt_byte,
  output logic             rt_valid,
  output logic [ERR_W-1:0] err_count
);

  parse_state_t state, state_nxt;
  logic [3:0]   rs_nib, rs_nib_nxt;
  logic [3:0]   rs_chan, rs_chan_nxt;
  logic [6:0]   d1_q, d1_nxt;
  // Set while WAIT_D1 was entered straight from a status byte (nothing delivered yet).
  logic         fresh, fresh_nxt;

  logic         accept;
  logic         done;
  logic         keep;
  logic [6:0]   done_d1;
  logic [6:0]   done_d2;
  msg_type_t    done_type;
  logic         err_inc;
  logic         rt_hit;

  assign in_ready = !reset && !(msg_valid && !msg_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_nxt   = state;
    rs_nib_nxt  = rs_nib;
    rs_chan_nxt = rs_chan;
    d1_nxt      = d1_q;
    fresh_nxt   = fresh;
    done        = 1'b0;
    done_d1     = '0;
    done_d2     = '0;
    err_inc     = 1'b0;
    rt_hit      = 1'b0;

    if (accept) begin
      if (in_data >= RT_MIN) begin
        rt_hit = 1'b1;
      end else if (in_data[7]) begin
        if (in_data < SYS_EX) begin
          if (state == S_WAIT_D2 || (state == S_WAIT_D1 && fresh))
            err_inc = 1'b1;
          rs_nib_nxt  = in_data[7:4];
          rs_chan_nxt = in_data[3:0];
          state_nxt   = S_WAIT_D1;
          fresh_nxt   = 1'b1;
        end else begin
          rs_nib_nxt  = '0;
          rs_chan_nxt = '0;
          fresh_nxt   = 1'b0;
          case (in_data)
            SYS_EX:       state_nxt = S_SYSEX;
            8'hF1, 8'hF3: state_nxt = S_SKIP1;
            8'hF2:        state_nxt = S_SKIP2;
            default:      state_nxt = S_IDLE;   // F4..F7, including EOX
          endcase
        end
      end else begin
        case (state)
          S_IDLE: err_inc = 1'b1;
          S_WAIT_D1: begin
            if (rs_nib == ST_PROG || rs_nib == ST_CHAN_AT) begin
              done      = 1'b1;
              done_d1   = in_data[6:0];
              fresh_nxt = 1'b0;
            end else begin
              d1_nxt    = in_data[6:0];
              state_nxt = S_WAIT_D2;
            end
          end
          S_WAIT_D2: begin
            done      = 1'b1;
            done_d1   = d1_q;
            done_d2   = in_data[6:0];
            state_nxt = S_WAIT_D1;
            fresh_nxt = 1'b0;
          end
          S_SKIP2: state_nxt = S_SKIP1;
          S_SKIP1: state_nxt = S_IDLE;
          default: state_nxt = state;       // SysEx payload
        endcase
      end
    end

    keep      = done && (omni || rs_chan == channel);
    done_type = nibble_to_type(rs_nib);
    if (VEL0_IS_OFF && done_type == NOTE_ON && done_d2 == 7'd0)
      done_type = NOTE_OFF;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      rs_nib    <= '0;
      rs_chan   <= '0;
      d1_q      <= '0;
      fresh     <= 1'b0;
      msg_type  <= NOTE_OFF;
      msg_chan  <= '0;
      msg_d1    <= '0;
      msg_d2    <= '0;
      msg_valid <= 1'b0;
      rt_byte   <= '0;
      rt_valid  <= 1'b0;
      err_count <= '0;
    end else begin
      state    <= state_nxt;
      rs_nib   <= rs_nib_nxt;
      rs_chan  <= rs_chan_nxt;
      d1_q     <= d1_nxt;
      fresh    <= fresh_nxt;
      rt_valid <= rt_hit;
      if (rt_hit)
        rt_byte <= in_data;
      if (err_inc && err_count != {ERR_W{1'b1}})
        err_count <= err_count + ERR_W'(1);
      // A byte is only accepted when the register is empty or draining this cycle.
      if (keep) begin
        msg_type  <= done_type;
        msg_chan  <= rs_chan;
        msg_d1    <= done_d1;
        msg_d2    <= done_d2;
        msg_valid <= 1'b1;
      end else if (msg_ready) begin
        msg_valid <= 1'b0;
      end
    end
  end

endmodule
